// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg
//   Shared definitions for the sequential ALU: opcode encodings, the
//   handshake FSM state type and the state width.
//   Optional feature macro used by the design: SEQ_ALU_MUL_EN.
package seq_alu_pkg;

  localparam int STATE_W = 2;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDC = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SUBB = 4'h3;
  localparam logic [3:0] OP_DEC  = 4'h4;
  localparam logic [3:0] OP_INC  = 4'h5;
  localparam logic [3:0] OP_TRAN = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_NOT  = 4'hA;
  localparam logic [3:0] OP_SHL  = 4'hB;
  localparam logic [3:0] OP_SHR  = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul
//   Unsigned shift-add multiplier. A start pulse loads the operands; the
//   product is built one partial product per cycle over WIDTH cycles.
//   done rises after the last step and stays high until the next start.
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   start         load operands and begin iterating
//   opd_a, opd_b  multiplicand / multiplier (WIDTH bits)
//   busy          iteration in progress
//   done          product valid
//   product       2*WIDTH bit result
module seq_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   opd_a,
  input  logic [WIDTH-1:0]   opd_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      cnt_reg;
  logic               busy_reg;
  logic               done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else if (start) begin
      acc_reg    <= '0;
      mcand_reg  <= {{WIDTH{1'b0}}, opd_a};
      mplier_reg <= opd_b;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
      done_reg   <= 1'b0;
    end else if (busy_reg) begin
      // Add the shifted multiplicand when the current multiplier LSB is set.
      if (mplier_reg[0])
        acc_reg <= acc_reg + mcand_reg;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
      if (cnt_reg == CW'(WIDTH - 1)) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
      end
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = acc_reg;

endmodule

// File: rtl/seq_alu.sv
// seq_alu
//   Registered ALU with valid/ready handshakes on both sides. A persistent
//   carry register chains ADDC/SUBB across operations. Illegal opcodes give
//   res=0 and raise err_flag.
//   Macro SEQ_ALU_MUL_EN: when defined, opcode D runs a WIDTH-cycle
//   shift-add multiply in seq_alu_mul; when undefined, D is illegal.
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    operand-side handshake (opcode, opd_1, opd_2)
//   out_valid/out_ready  result-side handshake
//   res                  2*WIDTH bit result
//   c_flag, z_flag       carry/borrow register, result-is-zero
//   err_flag             last operation had an illegal opcode
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   opd_1,
  input  logic [WIDTH-1:0]   opd_2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res,
  output logic               c_flag,
  output logic               z_flag,
  output logic               err_flag
);

  state_t             state_reg, state_next;
  logic [3:0]         op_reg;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [2*WIDTH-1:0] res_reg;
  logic               c_reg, z_reg, err_reg;

  logic               accept;
  logic [2*WIDTH-1:0] a_ext, b_ext, c_ext;
  logic [2*WIDTH-1:0] alu_res;
  logic               alu_c, alu_err, alu_z;
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign accept = (state_reg == ST_IDLE) && in_valid;

`ifdef SEQ_ALU_MUL_EN
  assign mul_start = accept && (opcode == OP_MUL);

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .opd_a   (opd_1),
    .opd_b   (opd_2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign mul_start   = 1'b0;
  assign mul_busy    = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // Single-cycle datapath on the latched operands; carry-in is the
  // registered c_flag captured at acceptance (it cannot change before EXEC).
  assign a_ext = {{WIDTH{1'b0}}, a_reg};
  assign b_ext = {{WIDTH{1'b0}}, b_reg};
  assign c_ext = {{(2*WIDTH-1){1'b0}}, c_reg};

  always_comb begin
    alu_res = '0;
    alu_c   = c_reg;
    alu_err = 1'b0;
    case (op_reg)
      OP_ADD:  begin alu_res = a_ext + b_ext;          alu_c = 1'b0;           end
      OP_ADDC: begin alu_res = a_ext + b_ext + c_ext;  alu_c = alu_res[WIDTH]; end
      OP_SUB:  begin alu_res = a_ext - b_ext;          alu_c = 1'b0;           end
      OP_SUBB: begin alu_res = a_ext - b_ext - c_ext;  alu_c = alu_res[WIDTH]; end
      OP_DEC:  begin alu_res = a_ext - 1'b1;           alu_c = alu_res[WIDTH]; end
      OP_INC:  begin alu_res = a_ext + 1'b1;           alu_c = alu_res[WIDTH]; end
      OP_TRAN: alu_res = a_ext;
      OP_AND:  alu_res = a_ext & b_ext;
      OP_OR:   alu_res = a_ext | b_ext;
      OP_XOR:  alu_res = a_ext ^ b_ext;
      OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~a_reg};
      OP_SHL:  alu_res = a_ext << 1;
      OP_SHR:  alu_res = a_ext >> 1;
      default: begin alu_res = '0; alu_c = 1'b0; alu_err = 1'b1; end
    endcase
    alu_z = !alu_err && (alu_res == '0);
  end

  // Handshake FSM
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept)
          state_next = mul_start ? ST_MUL : ST_EXEC;
      end
      ST_EXEC: state_next = ST_DONE;
      ST_MUL: begin
        if (mul_done && !mul_busy)
          state_next = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      c_reg     <= 1'b0;
      z_reg     <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg <= opcode;
        a_reg  <= opd_1;
        b_reg  <= opd_2;
      end
      if (state_reg == ST_EXEC) begin
        res_reg <= alu_res;
        c_reg   <= alu_c;
        z_reg   <= alu_z;
        err_reg <= alu_err;
      end else if (state_reg == ST_MUL && mul_done && !mul_busy) begin
        // Carry is left untouched by MUL.
        res_reg <= mul_product;
        z_reg   <= (mul_product == '0);
        err_reg <= 1'b0;
      end
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign res       = res_reg;
  assign c_flag    = c_reg;
  assign z_flag    = z_reg;
  assign err_flag  = err_reg;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu
//   Directed testbench for seq_alu (WIDTH=8). Expected values are
//   hand-computed constants. Honours SEQ_ALU_MUL_EN for the MUL checks.
module tb_seq_alu;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     opcode;
  logic [W-1:0]   opd_1, opd_2;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] res;
  logic           c_flag, z_flag, err_flag;

  int checks   = 0;
  int failures = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .opd_1     (opd_1),
    .opd_2     (opd_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .c_flag    (c_flag),
    .z_flag    (z_flag),
    .err_flag  (err_flag)
  );

  always #5 clk = ~clk;

  // Present one operation in IDLE, return the number of clock edges from the
  // accepting edge (counted as 1) to the edge after which out_valid is high.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int lat);
    opcode   = op;
    opd_1    = a;
    opd_2    = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; opd_1 = '0; opd_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (res !== 16'h0000) begin failures++; $display("FAIL reset_res got=%h want=0000", res); end
    checks++; if ({c_flag, z_flag, err_flag} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {c_flag, z_flag, err_flag}); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    $display("reset: res=%h c=%b z=%b err=%b in_ready=%b", res, c_flag, z_flag, err_flag, in_ready);
  endtask

  task automatic test_addc();
    int lat;
    issue(4'h1, 8'hFF, 8'h01, lat);
    $display("ADDC FF,01: res=%h c=%b z=%b lat=%0d", res, c_flag, z_flag, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL addc_latency got=%0d want=2", lat); end
    checks++; if ({res, c_flag, z_flag} !== {16'h0100, 1'b1, 1'b0}) begin failures++; $display("FAIL addc1 got res=%h c=%b z=%b want res=0100 c=1 z=0", res, c_flag, z_flag); end
    consume();
    issue(4'h1, 8'h10, 8'h20, lat);
    $display("ADDC 10,20: res=%h c=%b z=%b", res, c_flag, z_flag);
    checks++; if ({res, c_flag} !== {16'h0031, 1'b0}) begin failures++; $display("FAIL addc2 got res=%h c=%b want res=0031 c=0", res, c_flag); end
    consume();
  endtask

  task automatic test_subb();
    int lat;
    issue(4'h3, 8'h00, 8'h01, lat);
    $display("SUBB 00,01: res=%h c=%b z=%b", res, c_flag, z_flag);
    checks++; if ({res, c_flag, z_flag} !== {16'hFFFF, 1'b1, 1'b0}) begin failures++; $display("FAIL subb got res=%h c=%b z=%b want res=ffff c=1 z=0", res, c_flag, z_flag); end
    consume();
    issue(4'h2, 8'h05, 8'h05, lat);
    $display("SUB 05,05: res=%h c=%b z=%b", res, c_flag, z_flag);
    checks++; if ({res, c_flag, z_flag} !== {16'h0000, 1'b0, 1'b1}) begin failures++; $display("FAIL sub_zero got res=%h c=%b z=%b want res=0000 c=0 z=1", res, c_flag, z_flag); end
    consume();
  endtask

  task automatic test_mul();
    int lat;
    // Set carry first so "carry unchanged" is observable.
    issue(4'h1, 8'hFF, 8'h01, lat);
    consume();
    issue(4'hD, 8'hFF, 8'hFF, lat);
    $display("MUL FF,FF: res=%h c=%b z=%b err=%b lat=%0d", res, c_flag, z_flag, err_flag, lat);
`ifdef SEQ_ALU_MUL_EN
    checks++; if (lat !== W + 2) begin failures++; $display("FAIL mul_latency got=%0d want=%0d", lat, W + 2); end
    checks++; if ({res, c_flag, z_flag, err_flag} !== {16'hFE01, 1'b1, 1'b0, 1'b0}) begin failures++; $display("FAIL mul got res=%h c=%b z=%b err=%b want res=fe01 c=1 z=0 err=0", res, c_flag, z_flag, err_flag); end
`else
    checks++; if (lat !== 2) begin failures++; $display("FAIL mul_latency got=%0d want=2", lat); end
    checks++; if ({res, c_flag, z_flag, err_flag} !== {16'h0000, 1'b0, 1'b0, 1'b1}) begin failures++; $display("FAIL mul_illegal got res=%h c=%b z=%b err=%b want res=0000 c=0 z=0 err=1", res, c_flag, z_flag, err_flag); end
`endif
    consume();
    issue(4'hD, 8'h0C, 8'h0A, lat);
    $display("MUL 0C,0A: res=%h err=%b", res, err_flag);
`ifdef SEQ_ALU_MUL_EN
    checks++; if ({res, err_flag} !== {16'h0078, 1'b0}) begin failures++; $display("FAIL mul2 got res=%h err=%b want res=0078 err=0", res, err_flag); end
`else
    checks++; if ({res, err_flag} !== {16'h0000, 1'b1}) begin failures++; $display("FAIL mul2 got res=%h err=%b want res=0000 err=1", res, err_flag); end
`endif
    consume();
  endtask

  task automatic test_illegal();
    int lat;
    // Set carry so the clear-to-zero on an illegal opcode is visible.
    issue(4'h5, 8'hFF, 8'h00, lat);
    consume();
    issue(4'hF, 8'h12, 8'h34, lat);
    $display("ILLEGAL F: res=%h c=%b z=%b err=%b", res, c_flag, z_flag, err_flag);
    checks++; if ({res, c_flag, z_flag, err_flag} !== {16'h0000, 1'b0, 1'b0, 1'b1}) begin failures++; $display("FAIL illegal got res=%h c=%b z=%b err=%b want res=0000 c=0 z=0 err=1", res, c_flag, z_flag, err_flag); end
    consume();
    issue(4'hE, 8'h00, 8'h00, lat);
    checks++; if (err_flag !== 1'b1) begin failures++; $display("FAIL illegal_e got err=%b want 1", err_flag); end
    consume();
    issue(4'h7, 8'hF0, 8'h0F, lat);
    $display("AND F0,0F: res=%h z=%b err=%b", res, z_flag, err_flag);
    checks++; if ({res, z_flag, err_flag} !== {16'h0000, 1'b1, 1'b0}) begin failures++; $display("FAIL and_after_illegal got res=%h z=%b err=%b want res=0000 z=1 err=0", res, z_flag, err_flag); end
    consume();
  endtask

  task automatic test_hold();
    int lat;
    issue(4'h9, 8'h55, 8'h0F, lat);
    $display("XOR 55,0F: res=%h", res);
    checks++; if (res !== 16'h005A) begin failures++; $display("FAIL xor got=%h want=005a", res); end
    // A new request must be ignored while the result is pending.
    opcode = 4'h0; opd_1 = 8'h01; opd_2 = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      $display("hold cycle %0d: out_valid=%b in_ready=%b res=%h", i, out_valid, in_ready, res);
      checks++;
      if ({out_valid, in_ready, res, c_flag, z_flag, err_flag} !== {1'b1, 1'b0, 16'h005A, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL hold_%0d got ov=%b ir=%b res=%h c=%b z=%b err=%b want ov=1 ir=0 res=005a c=0 z=0 err=0",
                 i, out_valid, in_ready, res, c_flag, z_flag, err_flag);
      end
    end
    in_valid = 1'b0;
    consume();
    checks++; if ({out_valid, in_ready, res} !== {1'b0, 1'b1, 16'h005A}) begin failures++; $display("FAIL after_hold got ov=%b ir=%b res=%h want ov=0 ir=1 res=005a", out_valid, in_ready, res); end
  endtask

  task automatic test_mul_abort();
    int lat;
    // Make flags nonzero so the reset clearing is visible.
    issue(4'h1, 8'hFF, 8'h01, lat);
    consume();
    opcode = 4'hD; opd_1 = 8'h12; opd_2 = 8'h34; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    $display("abort: out_valid=%b res=%h c=%b z=%b err=%b", out_valid, res, c_flag, z_flag, err_flag);
    checks++; if ({out_valid, res, c_flag, z_flag, err_flag} !== {1'b0, 16'h0000, 3'b000}) begin failures++; $display("FAIL abort got ov=%b res=%h flags=%b%b%b want ov=0 res=0000 flags=000", out_valid, res, c_flag, z_flag, err_flag); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    issue(4'h0, 8'h01, 8'h02, lat);
    $display("ADD 01,02 after abort: res=%h lat=%0d", res, lat);
    checks++; if ({res, lat} !== {16'h0003, 32'd2}) begin failures++; $display("FAIL add_after_abort got res=%h lat=%0d want res=0003 lat=2", res, lat); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [3:0]     ops [10] = '{4'h5, 4'h4, 4'hA, 4'hB, 4'hC, 4'h8, 4'h6, 4'h0, 4'h3, 4'h4};
    logic [W-1:0]   as  [10] = '{8'hFF, 8'h00, 8'h0F, 8'h81, 8'h81, 8'h0F, 8'hAB, 8'h01, 8'h05, 8'h01};
    logic [W-1:0]   bs  [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h01, 8'h03, 8'h00};
    logic [2*W-1:0] er  [10] = '{16'h0100, 16'hFFFF, 16'h00F0, 16'h0102, 16'h0040, 16'h00FF, 16'h00AB, 16'h0002, 16'h0002, 16'h0000};
    logic           ec  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic           ez  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 10; i++) begin
      issue(ops[i], as[i], bs[i], lat);
      $display("op=%h a=%h b=%h: res=%h c=%b z=%b lat=%0d", ops[i], as[i], bs[i], res, c_flag, z_flag, lat);
      checks++;
      if ({res, c_flag, z_flag, err_flag, lat} !== {er[i], ec[i], ez[i], 1'b0, 32'd2}) begin
        failures++;
        $display("FAIL b2b_%0d got res=%h c=%b z=%b err=%b lat=%0d want res=%h c=%b z=%b err=0 lat=2",
                 i, res, c_flag, z_flag, err_flag, lat, er[i], ec[i], ez[i]);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_addc();
    test_subb();
    test_mul();
    test_illegal();
    test_hold();
    test_mul_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
